// File: rtl/cache_pkg.sv
// Shared widths and the eviction record for the set-associative L1 cache memory.
// The typedefs describe the default geometry; the cache itself is parameterised.
package cache_pkg;

    localparam int SETS_DEF      = 32;
    localparam int LINE_BITS_DEF = 64;
    localparam int TAG_BITS_DEF  = 8;
    localparam int IDX_BITS_DEF  = $clog2(SETS_DEF);

    typedef logic [LINE_BITS_DEF-1:0] line_t;
    typedef logic [TAG_BITS_DEF-1:0]  tag_t;
    typedef logic [IDX_BITS_DEF-1:0]  idx_t;

    typedef struct packed {
        idx_t  idx;
        tag_t  tag;
        line_t data;
    } evict_t;

    // A way index needs at least one bit, even for a direct-mapped build.
    function automatic int way_w(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/assoc_cachemem_lru_ages.sv
// True-LRU age vector for one set: ages are a permutation of 0..ASSOC-1,
// 0 is most recently used and the way holding ASSOC-1 is the victim.
module lru_ages #(
    parameter int ASSOC = 2,
    parameter int WAY_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way
);

    if (ASSOC == 1) begin : g_single
        logic unused;
        assign unused     = ^{clock, reset, touch_en, touch_way};
        assign victim_way = '0;
    end else begin : g_lru
        logic [ASSOC-1:0][WAY_W-1:0] age;

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int w = 0; w < ASSOC; w++) age[w] <= WAY_W'(w);
            end else if (touch_en) begin
                // Only ways younger than the touched one shift back by one.
                for (int w = 0; w < ASSOC; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age[w] <= '0;
                    else if (age[w] < age[touch_way])
                        age[w] <= age[w] + 1'b1;
                end
            end
        end

        always_comb begin
            victim_way = '0;
            for (int w = 0; w < ASSOC; w++)
                if (age[w] == WAY_W'(ASSOC - 1)) victim_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/assoc_cachemem.sv
// Set-associative cache memory: combinational lookup ports, one write/fill port,
// invalidate, per-set true LRU and a registered dirty-victim eviction output.
module assoc_cachemem
    import cache_pkg::*;
#(
    parameter int SETS      = SETS_DEF,
    parameter int ASSOC     = 2,
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int TAG_BITS  = TAG_BITS_DEF,
    parameter int RD_PORTS  = 3,
    localparam int IDX_BITS = $clog2(SETS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [RD_PORTS-1:0][IDX_BITS-1:0]   rd_idx,
    input  logic [RD_PORTS-1:0][TAG_BITS-1:0]   rd_tag,
    input  logic [RD_PORTS-1:0]                 rd_use,
    output logic [RD_PORTS-1:0][LINE_BITS-1:0]  rd_data,
    output logic [RD_PORTS-1:0]                 rd_hit,
    input  logic                                wr_en,
    input  logic [IDX_BITS-1:0]                 wr_idx,
    input  logic [TAG_BITS-1:0]                 wr_tag,
    input  logic [LINE_BITS-1:0]                wr_data,
    input  logic                                wr_dirty,
    input  logic                                inv_en,
    input  logic [IDX_BITS-1:0]                 inv_idx,
    input  logic [TAG_BITS-1:0]                 inv_tag,
    output logic                                evict_valid,
    output logic [IDX_BITS-1:0]                 evict_idx,
    output logic [TAG_BITS-1:0]                 evict_tag,
    output logic [LINE_BITS-1:0]                evict_data
);

    localparam int WAY_W = way_w(ASSOC);

    typedef struct packed {
        logic [IDX_BITS-1:0]  idx;
        logic [TAG_BITS-1:0]  tag;
        logic [LINE_BITS-1:0] data;
    } ev_rec_t;

    logic [ASSOC-1:0]     valid    [SETS];
    logic [ASSOC-1:0]     dirty    [SETS];
    logic [TAG_BITS-1:0]  tag_mem  [SETS][ASSOC];
    logic [LINE_BITS-1:0] data_mem [SETS][ASSOC];

    logic [SETS-1:0][WAY_W-1:0]     victim_way;
    logic [SETS-1:0][WAY_W-1:0]     touch_way;
    logic [SETS-1:0]                touch_en;
    logic [RD_PORTS-1:0][WAY_W-1:0] rd_way;

    logic             wr_hit, wr_inv_seen, wr_evict;
    logic [WAY_W-1:0] wr_hit_way, wr_vic_way, wr_way;
    logic             inv_hit, inv_same, inv_dirty, inv_do, inv_evict;
    logic [WAY_W-1:0] inv_way;

    logic    ev_fire;
    ev_rec_t ev_now, ev_pend, ev_out;
    logic [1:0] vld_pipe;

    // Lookups see only pre-clock state; there is no write bypass.
    always_comb begin
        rd_hit  = '0;
        rd_data = '0;
        rd_way  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (valid[rd_idx[p]][w] && tag_mem[rd_idx[p]][w] == rd_tag[p]) begin
                    rd_hit[p]  = 1'b1;
                    rd_data[p] = data_mem[rd_idx[p]][w];
                    rd_way[p]  = WAY_W'(w);
                end
            end
        end
    end

    // Write way: hit way, else lowest invalid way, else the LRU victim.
    always_comb begin
        wr_hit      = 1'b0;
        wr_hit_way  = '0;
        wr_inv_seen = 1'b0;
        wr_vic_way  = victim_way[wr_idx];
        for (int w = 0; w < ASSOC; w++) begin
            if (valid[wr_idx][w] && tag_mem[wr_idx][w] == wr_tag) begin
                wr_hit     = 1'b1;
                wr_hit_way = WAY_W'(w);
            end
            if (!valid[wr_idx][w] && !wr_inv_seen) begin
                wr_inv_seen = 1'b1;
                wr_vic_way  = WAY_W'(w);
            end
        end
        wr_way   = wr_hit ? wr_hit_way : wr_vic_way;
        wr_evict = wr_en && !wr_hit && valid[wr_idx][wr_way] && dirty[wr_idx][wr_way];
    end

    // An invalidate loses to a write on the same set, or to a write eviction.
    always_comb begin
        inv_hit = 1'b0;
        inv_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid[inv_idx][w] && tag_mem[inv_idx][w] == inv_tag) begin
                inv_hit = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        inv_same  = wr_en && (wr_idx == inv_idx);
        inv_dirty = dirty[inv_idx][inv_way];
        inv_do    = inv_en && inv_hit && !inv_same && !(wr_evict && inv_dirty);
        inv_evict = inv_do && inv_dirty;
    end

    // Per-set touch arbitration: later assignments win, so walk low priority first.
    always_comb begin
        touch_en  = '0;
        touch_way = '0;
        for (int p = RD_PORTS - 1; p >= 0; p--) begin
            if (rd_use[p] && rd_hit[p]) begin
                touch_en[rd_idx[p]]  = 1'b1;
                touch_way[rd_idx[p]] = rd_way[p];
            end
        end
        if (wr_en) begin
            touch_en[wr_idx]  = 1'b1;
            touch_way[wr_idx] = wr_way;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        lru_ages #(
            .ASSOC (ASSOC),
            .WAY_W (WAY_W)
        ) u_lru (
            .clock      (clock),
            .reset      (reset),
            .touch_en   (touch_en[s]),
            .touch_way  (touch_way[s]),
            .victim_way (victim_way[s])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            if (inv_do) begin
                valid[inv_idx][inv_way] <= 1'b0;
                dirty[inv_idx][inv_way] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_idx][wr_way] <= 1'b1;
                dirty[wr_idx][wr_way] <= wr_hit ? (dirty[wr_idx][wr_way] | wr_dirty) : wr_dirty;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            tag_mem[wr_idx][wr_way]  <= wr_tag;
            data_mem[wr_idx][wr_way] <= wr_data;
        end
    end

    always_comb begin
        ev_fire     = wr_evict || inv_evict;
        ev_now.idx  = wr_evict ? wr_idx : inv_idx;
        ev_now.tag  = wr_evict ? tag_mem[wr_idx][wr_way]  : tag_mem[inv_idx][inv_way];
        ev_now.data = wr_evict ? data_mem[wr_idx][wr_way] : data_mem[inv_idx][inv_way];
    end

    // The victim is captured as it is overwritten and presented one edge later,
    // so a reset on that following edge can still cancel the pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            ev_pend  <= '0;
            ev_out   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], ev_fire};
            if (ev_fire)     ev_pend <= ev_now;
            if (vld_pipe[0]) ev_out  <= ev_pend;
        end
    end

    assign evict_valid = vld_pipe[1];
    assign evict_idx   = ev_out.idx;
    assign evict_tag   = ev_out.tag;
    assign evict_data  = ev_out.data;

endmodule
